// File: rtl/alu_rf_pkg.sv
// Shared definitions for the ALUAndRF instruction sequencer: opcodes,
// datapath control encodings, FSM states and instruction-field helpers.
package alu_rf_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b00;

  localparam logic [1:0] REGWRITE_ON  = 2'b01;
  localparam logic [1:0] REGWRITE_OFF = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  // Decoded view of one instruction word
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [3:0]  func4;
    logic [15:0] imm;
    logic [4:0]  dest;
    logic        is_rtype;
    logic        is_lui;
    logic        is_illegal;
  } dec_t;

  function automatic logic [5:0] f_op(input logic [31:0] w);
    return w[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] w);
    return w[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] w);
    return w[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] w);
    return w[15:11];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] w);
    return w[5:0];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] w);
    return w[15:0];
  endfunction

endpackage

// File: rtl/alu_rf_instr_decode.sv
// Combinational decode of a MIPS-format word into fields, class flags
// and the register-file destination (rd for R-type, rt for LUI).
module alu_rf_instr_decode
  import alu_rf_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] op;
  logic [5:0] funct;

  // Field extraction and classification
  always_comb begin
    dec_o            = '0;
    op               = f_op(instr_i);
    funct            = f_funct(instr_i);
    dec_o.rs         = f_rs(instr_i);
    dec_o.rt         = f_rt(instr_i);
    dec_o.func4      = funct[3:0];
    dec_o.imm        = f_imm(instr_i);
    dec_o.is_rtype   = (op == OP_RTYPE);
    dec_o.is_lui     = (op == OP_LUI);
    dec_o.is_illegal = !(dec_o.is_rtype || dec_o.is_lui);
    dec_o.dest       = dec_o.is_rtype ? f_rd(instr_i) : f_rt(instr_i);
  end

endmodule

// File: rtl/alu_rf_sequencer.sv
// Instruction-issue controller for ALUAndRF: accepts one instruction at a
// time, runs R-type through EXEC then WB, LUI straight to WB, and reports
// each retirement on a one-cycle result strobe.
module alu_rf_sequencer
  import alu_rf_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter logic [1:0]  ALU_OP_RTYPE = ALUOP_RTYPE,
  parameter logic [1:0]  ALU_OP_PASS  = ALUOP_PASS,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [4:0]        Read1,
  output logic [4:0]        Read2,
  output logic [4:0]        WriteReg,
  output logic [1:0]        RegWrite,
  output logic [DATA_W-1:0] WriteData,
  output logic [3:0]        FuncCode,
  output logic [1:0]        ALUOp,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic              Zero,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_cnt
);

  state_e state_q, state_d;
  dec_t   dec;
  logic   accept;

  logic [4:0]        read1_q, read2_q, dest_q;
  logic [3:0]        func_q;
  logic [15:0]       imm_q;
  logic              is_lui_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] wb_data;

  alu_rf_instr_decode u_decode (
    .instr_i (instr),
    .dec_o   (dec)
  );

  assign accept  = instr_valid && (state_q == S_IDLE);
  assign wb_data = is_lui_q ? DATA_W'({imm_q, 16'h0000}) : result_q;

  assign Read1       = read1_q;
  assign Read2       = read2_q;
  assign FuncCode    = func_q;
  assign illegal     = illegal_q;
  assign retired_cnt = cnt_q;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-state datapath control; WB outputs are decoded from
  // state so an asynchronous reset kills a write-back immediately.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    ALUOp       = ALU_OP_PASS;
    RegWrite    = REGWRITE_OFF;
    WriteReg    = '0;
    WriteData   = '0;
    res_valid   = 1'b0;
    res_zero    = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (dec.is_rtype)    state_d = S_EXEC;
          else if (dec.is_lui) state_d = S_WB;
        end
      end
      S_EXEC: begin
        ALUOp   = ALU_OP_RTYPE;
        state_d = S_WB;
      end
      S_WB: begin
        WriteReg  = dest_q;
        WriteData = wb_data;
        RegWrite  = (dest_q != 5'd0) ? REGWRITE_ON : REGWRITE_OFF;
        ALUOp     = is_lui_q ? ALU_OP_PASS : ALU_OP_RTYPE;
        res_valid = 1'b1;
        res_zero  = is_lui_q ? 1'b0 : zero_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    res_data = WriteData;
  end

  // Instruction capture, ALU result capture, illegal strobe and retire count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read1_q   <= '0;
      read2_q   <= '0;
      func_q    <= '0;
      dest_q    <= '0;
      imm_q     <= '0;
      is_lui_q  <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= accept && dec.is_illegal;
      if (accept && !dec.is_illegal) begin
        dest_q   <= dec.dest;
        imm_q    <= dec.imm;
        is_lui_q <= dec.is_lui;
      end
      // Read ports only move for R-type so they hold across LUI and idle
      if (accept && dec.is_rtype) begin
        read1_q <= dec.rs;
        read2_q <= dec.rt;
        func_q  <= dec.func4;
      end
      if (state_q == S_EXEC) begin
        result_q <= ALUOut;
        zero_q   <= Zero;
      end
      // Counted on entry to WB so the count is already visible with res_valid
      if (state_d == S_WB) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
